if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction fetch queue between the IF stage and the ID stage. It sends the IF stage's current instruction address to instruction memory over a req/ack/rvalid handshake and buffers returned instructions, with their PC and PC+4, in a DEPTH-entry FIFO. It delivers them to ID over a valid/ready handshake. It tells IF when to advance the PC, and it drops queued and in-flight fetches on a branch/jump flush.

## Interface
- DEPTH, 2, FIFO entries; power of two, >= 2
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- fetch_addr  input  32  current PC from IF (inst_addr)
- fetch_pc4  input  32  PC+4 from IF
- pc_advance  output  1  IF may load its next PC this edge (request accepted)
- flush  input  1  branch/jump redirect; discard everything
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address (= fetch_addr)
- imem_ack  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid this cycle
- imem_rdata  input  32  instruction word
- id_valid  output  1  head entry available to ID
- id_ready  input  1  ID consumes head this cycle
- id_inst  output  32  head instruction; 32'h00000013 (NOP) when id_valid=0
- id_pc  output  32  head PC; 0 when id_valid=0
- id_pc4  output  32  head PC+4; 0 when id_valid=0

## Operation
- The FSM has three states: IDLE, WAIT and DROP. There is at most one outstanding memory request.
- IDLE:
  - imem_req = !reset && !flush && (count < DEPTH).
  - imem_addr = fetch_addr.
  - On imem_req && imem_ack: pc_advance=1, latch req_pc=fetch_addr and req_pc4=fetch_pc4, go to WAIT.
  - Otherwise pc_advance=0.
- WAIT: imem_req=0, pc_advance=0.
  - imem_rvalid && !flush: push {req_pc, req_pc4, imem_rdata}, go to IDLE.
  - imem_rvalid && flush: discard the data, go to IDLE.
  - !imem_rvalid && flush: go to DROP.
- DROP: imem_req=0. On imem_rvalid, discard the data and go to IDLE. A flush while in DROP stays in DROP.
- A slot is reserved at request time (count < DEPTH). A push can therefore never hit a full FIFO.
- FIFO:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - id_valid = (count != 0) && !flush.
  - pop = id_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
- Flush:
  - At the next edge, count and the pointers clear to 0.
  - Flush overrides any push and pop in the same cycle.
  - The IF stage loads the redirect target itself; this block never asserts pc_advance in a flush cycle.
- Reset (asynchronous, any time, including mid-request): state=IDLE, count=0, pointers=0, req_pc/req_pc4=0.
  - While reset is high: imem_req=0, pc_advance=0, id_valid=0, id_inst=NOP, id_pc=0, id_pc4=0.
  - A response that arrives after reset deasserts without a matching request is ignored, because IDLE ignores imem_rvalid.

## Timing
- Request and ack happen in cycle N. The earliest rvalid is cycle N+1. The entry is pushed at the end of N+1, and id_valid is high in N+2. There is no bypass path.
- Maximum throughput is 1 instruction per 2 cycles; requests are issued only from IDLE.
- imem_req, imem_addr, pc_advance and id_valid are combinational from state, count, flush and the inputs. Memory must not combinationally depend imem_ack on imem_rvalid.
- When the FIFO is full, imem_req stays low until a pop. The request can issue in the cycle after the pop edge.
- Outputs are held while id_valid=1 && id_ready=0; the head is stable until popped or flushed.

## Test plan
- Reset, then memory acks immediately and returns rvalid 1 cycle later with data 0x00500093 for fetch_addr 0x0, fetch_pc4 0x4. Required: pc_advance pulse in cycle 1, id_valid in cycle 3 with id_inst=0x00500093, id_pc=0x0, id_pc4=0x4.
- id_ready=0 and DEPTH=2, with fetches of 0x0 and 0x4. Required: FIFO fills to 2 and imem_req stays low. Raising id_ready pops 0x0 then 0x4 in order, and imem_req reasserts the cycle after the first pop.
- Flush while in WAIT with no rvalid, then rvalid 3 cycles later with 0xDEADBEEF. Required: state goes to DROP, the data is discarded, id_valid stays 0, and the next request uses the new fetch_addr 0x100.
- Flush in the same cycle as rvalid and id_ready with 2 entries queued. Required: no push, no pop, count=0 next cycle, and id_valid=0 in the flush cycle.
- Pop and push in the same cycle with count=1. Required: count stays 1, the pointers wrap correctly over 4 consecutive fetches, and PCs come out 0x0, 0x4, 0x8, 0xC in order.
- Assert reset for 1 cycle while in WAIT with 1 entry queued. Required: id_valid=0, id_inst=0x00000013 and imem_req=0 during reset. After reset, a stale rvalid is ignored and a fresh request issues from IDLE.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between IF and ID.
// Issues one outstanding fetch at a time, buffers returned instructions with
// their PC/PC+4 in a DEPTH-entry FIFO, and drops everything on a flush.
module if_fetch_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic [31:0] fetch_pc4,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);
    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrop
    } state_e;

    state_e state;

    logic [31:0] req_pc;
    logic [31:0] req_pc4;

    logic [31:0] mem_inst [DEPTH];
    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_pc4  [DEPTH];

    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW:0]   count;

    logic push;
    logic pop;

    // Request side: a slot is reserved at request time, so a later push never overflows.
    always_comb begin
        imem_req   = !reset && !flush && (state == StIdle) && (count < FullCount);
        imem_addr  = fetch_addr;
        pc_advance = imem_req && imem_ack;
        push       = (state == StWait) && imem_rvalid && !flush;
    end

    // Delivery side: head is hidden during reset and flush; idle values are NOP/0.
    always_comb begin
        id_valid = !reset && !flush && (count != '0);
        pop      = id_valid && id_ready;
        if (id_valid) begin
            id_inst = mem_inst[rd_ptr];
            id_pc   = mem_pc[rd_ptr];
            id_pc4  = mem_pc4[rd_ptr];
        end else begin
            id_inst = Nop;
            id_pc   = '0;
            id_pc4  = '0;
        end
    end

    // Fetch FSM: at most one request in flight; DROP swallows the response of a flushed fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            req_pc  <= '0;
            req_pc4 <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pc_advance) begin
                        req_pc  <= fetch_addr;
                        req_pc4 <= fetch_pc4;
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state <= StIdle;
                    end else if (flush) begin
                        state <= StDrop;
                    end
                end
                StDrop: begin
                    if (imem_rvalid) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // FIFO bookkeeping: flush wins over any simultaneous push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observable through a valid head, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= req_pc;
            mem_pc4[wr_ptr]  <= req_pc4;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed stimulus, scoreboard of
// expected ID-side entries, and a monitor that compares every pop.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_pc4;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    entry_t exp_q[$];
    entry_t exp_e;
    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_queue #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .fetch_pc4  (fetch_pc4),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop seen on the ID side must match the oldest expected entry.
    always @(negedge clk) begin
        if (id_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h, required no entry (t=%0t)", id_pc, $time);
            end else begin
                exp_e = exp_q.pop_front();
                check32("pop_inst", id_inst, exp_e.inst);
                check32("pop_pc", id_pc, exp_e.pc);
                check32("pop_pc4", id_pc4, exp_e.pc4);
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        flush       = 1'b0;
        id_ready    = 1'b0;
    endtask

    // One full fetch: request+ack in cycle A, rvalid in cycle B.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input logic rdy_a, input logic rdy_b);
        fetch_addr  = addr;
        fetch_pc4   = addr + 32'd4;
        imem_ack    = 1'b1;
        imem_rvalid = 1'b0;
        id_ready    = rdy_a;
        @(negedge clk);
        check1("fetch_req", imem_req, 1'b1);
        check1("fetch_adv", pc_advance, 1'b1);
        check32("fetch_addr", imem_addr, addr);
        tick();
        imem_ack    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        id_ready    = rdy_b;
        exp_q.push_back('{inst: data, pc: addr, pc4: addr + 32'd4});
        @(negedge clk);
        check1("wait_no_req", imem_req, 1'b0);
        check1("wait_no_adv", pc_advance, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        id_ready    = 1'b0;
    endtask

    task automatic drain1();
        id_ready = 1'b1;
        @(negedge clk);
        check1("drain_valid", id_valid, 1'b1);
        tick();
        id_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        fetch_addr = 32'h0;
        fetch_pc4  = 32'h4;
        imem_rdata = 32'h0;
        quiet();
        tick();
        imem_ack = 1'b1;
        @(negedge clk);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_adv", pc_advance, 1'b0);
        check1("rst_valid", id_valid, 1'b0);
        check32("rst_inst", id_inst, 32'h0000_0013);
        check32("rst_pc", id_pc, 32'h0);
        check32("rst_pc4", id_pc4, 32'h0);
        tick();
        reset = 1'b0;
        quiet();

        // Basic latency: advance in cycle 1, entry visible in cycle 3.
        fetch(32'h0, 32'h0050_0093, 1'b0, 1'b0);
        id_ready = 1'b1;
        @(negedge clk);
        check1("t1_valid", id_valid, 1'b1);
        check32("t1_inst", id_inst, 32'h0050_0093);
        check32("t1_pc", id_pc, 32'h0);
        check32("t1_pc4", id_pc4, 32'h4);
        tick();
        quiet();

        // Full FIFO holds off requests; reissue the cycle after the first pop.
        fetch(32'h0, 32'h1111_0001, 1'b0, 1'b0);
        fetch(32'h4, 32'h1111_0002, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check1("t2_full_req", imem_req, 1'b0);
            check32("t2_head_pc", id_pc, 32'h0);
            tick();
        end
        id_ready = 1'b1;
        @(negedge clk);
        check1("t2_pop_cycle_req", imem_req, 1'b0);
        tick();
        @(negedge clk);
        check1("t2_after_pop_req", imem_req, 1'b1);
        check32("t2_second_pc", id_pc, 32'h4);
        tick();
        quiet();
        @(negedge clk);
        check1("t2_empty", id_valid, 1'b0);
        tick();

        // Flush during WAIT: DROP swallows the late response.
        fetch_addr = 32'h8;
        fetch_pc4  = 32'hC;
        imem_ack   = 1'b1;
        @(negedge clk);
        check1("t3_adv", pc_advance, 1'b1);
        tick();
        imem_ack = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        check1("t3_flush_adv", pc_advance, 1'b0);
        check1("t3_flush_req", imem_req, 1'b0);
        tick();
        flush      = 1'b0;
        fetch_addr = 32'h100;
        fetch_pc4  = 32'h104;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check1("t3_drop_req", imem_req, 1'b0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check1("t3_drop_rv_req", imem_req, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        check1("t3_discard_valid", id_valid, 1'b0);
        check1("t3_new_req", imem_req, 1'b1);
        check32("t3_new_addr", imem_addr, 32'h100);
        tick();
        fetch(32'h100, 32'h2222_0001, 1'b0, 1'b0);
        drain1();

        // Flush with rvalid and id_ready: one queued plus one in flight.
        fetch(32'h200, 32'h3333_0001, 1'b0, 1'b0);
        fetch_addr = 32'h204;
        fetch_pc4  = 32'h208;
        imem_ack   = 1'b1;
        @(negedge clk);
        check1("t4a_adv", pc_advance, 1'b1);
        tick();
        imem_ack    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_0002;
        flush       = 1'b1;
        id_ready    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check1("t4a_flush_valid", id_valid, 1'b0);
        tick();
        quiet();
        id_ready = 1'b1;
        @(negedge clk);
        check1("t4a_after_valid", id_valid, 1'b0);
        check1("t4a_after_req", imem_req, 1'b1);
        tick();
        quiet();

        // Flush with rvalid and id_ready: two entries queued.
        fetch(32'h300, 32'h4444_0001, 1'b0, 1'b0);
        fetch(32'h304, 32'h4444_0002, 1'b0, 1'b0);
        flush       = 1'b1;
        imem_rvalid = 1'b1;
        imem_ack    = 1'b1;
        id_ready    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check1("t4b_flush_valid", id_valid, 1'b0);
        check1("t4b_flush_adv", pc_advance, 1'b0);
        check1("t4b_flush_req", imem_req, 1'b0);
        tick();
        quiet();
        @(negedge clk);
        check1("t4b_after_valid", id_valid, 1'b0);
        check1("t4b_after_req", imem_req, 1'b1);
        tick();

        // Simultaneous push/pop at count=1; pointers wrap across four fetches.
        fetch(32'h0, 32'h5555_0000, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            fetch(32'(i * 4), 32'h5555_0000 + 32'(i), 1'b0, 1'b1);
        end
        drain1();
        @(negedge clk);
        check1("t5_empty", id_valid, 1'b0);
        tick();

        // Reset mid-request with one entry queued.
        fetch(32'h500, 32'h6666_0001, 1'b0, 1'b0);
        fetch_addr = 32'h504;
        fetch_pc4  = 32'h508;
        imem_ack   = 1'b1;
        @(negedge clk);
        check1("t6_adv", pc_advance, 1'b1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check1("t6_rst_valid", id_valid, 1'b0);
        check32("t6_rst_inst", id_inst, 32'h0000_0013);
        check1("t6_rst_req", imem_req, 1'b0);
        check1("t6_rst_adv", pc_advance, 1'b0);
        tick();
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        check1("t6_stale_valid", id_valid, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        check1("t6_post_valid", id_valid, 1'b0);
        check1("t6_post_req", imem_req, 1'b1);
        tick();
        fetch(32'h600, 32'h7777_0001, 1'b0, 1'b0);
        drain1();
        tick();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_entries: got %0d, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
